fifo_ctrl: RTL
==============

Name: fifo_ctrl

Overview:
- Control sequencer for the circular-buffer FIFO datapath: write-pointer register, read-pointer register and storage buffer.
- Accepts write/read requests from producer and consumer.
- Generates the storage write/read load strobes and the addresses they use.
- Maintains occupancy and drives the full/empty flags that the datapath exports.

Parameters:
- K, 4, address width; FIFO depth = 2^K entries.
- ALMOST_TH, 2, threshold for almost flags (used only with ALMOST_FLAGS_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- wr_req  in  1  producer write request, level, sampled each rising edge.
- rd_req  in  1  consumer read request, level, sampled each rising edge.
- flush  in  1  synchronous FIFO clear request.
- ld_wr  out  1  storage write strobe; the datapath writes wr_addr this cycle.
- wr_addr  out  K  current write pointer.
- ld_rd  out  1  storage read strobe; the datapath reads rd_addr this cycle.
- rd_addr  out  K  current read pointer.
- rd_valid  out  1  read data valid at the datapath output, one cycle after ld_rd.
- full  out  1  count == 2^K.
- empty  out  1  count == 0.
- count  out  K+1  current occupancy, 0..2^K.
- ovf  out  1  one-cycle pulse: write rejected because FIFO full.
- unf  out  1  one-cycle pulse: read rejected because FIFO empty.

Behaviour:

Reset:
- While rst = 0: state S_EMPTY, wptr = rptr = 0, count = 0.
- Outputs: empty = 1, full = 0, rd_valid = 0, ovf = 0, unf = 0, ld_wr = ld_rd = 0.
- Reset asserted mid-operation discards all contents immediately. No strobe may be asserted during reset.

FSM states: S_EMPTY, S_MID, S_FULL, S_FLUSH.

Accept rules (combinational from state and requests, evaluated in the same cycle):
- wr_acc = wr_req & (state != S_FULL | rd_acc) & state != S_FLUSH & !flush.
- rd_acc = rd_req & state != S_EMPTY & state != S_FLUSH & !flush.

Strobes and addresses:
- ld_wr = wr_acc and ld_rd = rd_acc, both Mealy, same cycle as the request.
- wr_addr and rd_addr are registered pointers, so each address is stable for the whole cycle its strobe is high.

Pointer and count updates:
- On the edge after wr_acc: wptr += 1, modulo 2^K (natural wrap 2^K-1 -> 0).
- On the edge after rd_acc: rptr += 1, modulo 2^K.
- count += wr_acc - rd_acc. Simultaneous accept leaves count unchanged.

Transitions:
- S_EMPTY -> S_MID when wr_acc.
- S_MID -> S_FULL when count = 2^K-1 and wr_acc & !rd_acc.
- S_MID -> S_EMPTY when count = 1 and rd_acc & !wr_acc.
- S_FULL -> S_MID when rd_acc & !wr_acc.
- Any state -> S_FLUSH when flush = 1 (flush has priority over both requests).
- S_FLUSH lasts exactly one cycle: pointers and count are cleared, then the FSM goes to S_EMPTY. Requests arriving in the S_FLUSH cycle are ignored, with no ovf/unf.

Flags and pulses:
- full and empty are registered, decoded from the next state, and valid the cycle after the causing edge.
- rd_valid is registered: rd_valid(t+1) = rd_acc(t).
- Flush clears any pending rd_valid on the next edge.
- ovf(t+1) = wr_req & !wr_acc & state == S_FULL & !flush.
- unf(t+1) = rd_req & state == S_EMPTY & !flush.

Boundaries:
- Empty with simultaneous wr_req and rd_req: write accepted, read rejected (no fall-through), unf pulses.
- Full with simultaneous wr_req and rd_req: both accepted, state stays S_FULL.

Optional Feature:

FIFO_ALMOST_FLAGS_EN, when defined:
- Adds outputs almost_full (1 bit) = count >= 2^K - ALMOST_TH.
- Adds almost_empty (1 bit) = count <= ALMOST_TH.
- Both are registered like full/empty. Reset values: almost_full = 0, almost_empty = 1.

When not defined:
- The ports do not exist and no threshold logic is synthesized.
- All other behaviour is identical.

Test Plan:
- Reset: hold rst = 0 for 3 cycles with wr_req = rd_req = 1 -> ld_wr = ld_rd = 0, empty = 1, count = 0, wr_addr = rd_addr = 0.
- Fill: 16 consecutive wr_req (K = 4) -> ld_wr high 16 cycles, wr_addr 0..15 then 0, full = 1 and count = 16 the cycle after the 16th write. A 17th wr_req -> ld_wr = 0, ovf = 1 for one cycle.
- Drain: from full, 16 rd_req -> rd_addr 0..15, rd_valid lagging ld_rd by 1, empty = 1 after the last read. A further rd_req -> unf = 1 for one cycle.
- Simultaneous at full: wr_req = rd_req = 1 -> both strobes high, count stays 16, full stays 1. Simultaneous at empty -> only ld_wr, count = 1, unf = 1.
- Wrap and flush: write 20, read 10 -> wptr = 4, rptr = 10, count = 10. Then flush = 1 with wr_req = 1 -> no ld_wr. Next cycle: count = 0, pointers = 0, empty = 1.
- With FIFO_ALMOST_FLAGS_EN, ALMOST_TH = 2: count 13 -> almost_full = 0; count 14 -> almost_full = 1; count 2 -> almost_empty = 1; count 3 -> almost_empty = 0.

Source files
------------

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: control sequencer for a circular-buffer FIFO datapath.
//
// Drives the storage write/read strobes and their addresses, and tracks
// occupancy, full/empty flags and overflow/underflow pulses.
//
// Ports:
//   i_clk, i_rst_n         clock (rising edge), asynchronous active-low reset
//   i_wr_req, i_rd_req     producer/consumer requests, level, sampled per edge
//   i_flush                synchronous clear request (beats both requests)
//   o_ld_wr, o_wr_addr     storage write strobe (Mealy) and write pointer
//   o_ld_rd, o_rd_addr     storage read strobe (Mealy) and read pointer
//   o_rd_valid             read data valid, one cycle after o_ld_rd
//   o_full, o_empty        registered occupancy flags
//   o_count                occupancy, 0..2^K
//   o_ovf, o_unf           one-cycle pulses for a rejected write/read
//   o_almost_full, o_almost_empty  only when FIFO_ALMOST_FLAGS_EN is defined
//
// Optional feature macro: FIFO_ALMOST_FLAGS_EN (adds the almost flags and the
// ALMOST_TH parameter).
module fifo_ctrl #(
    parameter int unsigned K = 4
`ifdef FIFO_ALMOST_FLAGS_EN
    ,
    parameter int unsigned ALMOST_TH = 2
`endif
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_wr_req,
    input  logic         i_rd_req,
    input  logic         i_flush,
`ifdef FIFO_ALMOST_FLAGS_EN
    output logic         o_almost_full,
    output logic         o_almost_empty,
`endif
    output logic         o_ld_wr,
    output logic [K-1:0] o_wr_addr,
    output logic         o_ld_rd,
    output logic [K-1:0] o_rd_addr,
    output logic         o_rd_valid,
    output logic         o_full,
    output logic         o_empty,
    output logic [K:0]   o_count,
    output logic         o_ovf,
    output logic         o_unf
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_MID   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    localparam logic [K:0]   DEPTH  = {1'b1, {K{1'b0}}};
    localparam logic [K:0]   ONE    = {{K{1'b0}}, 1'b1};
    localparam logic [K:0]   LAST   = DEPTH - ONE;
    localparam logic [K-1:0] PTR_1  = {{(K-1){1'b0}}, 1'b1};

    logic [1:0]   r_state, w_state_d;
    logic [K-1:0] r_wptr, w_wptr_d;
    logic [K-1:0] r_rptr, w_rptr_d;
    logic [K:0]   r_count, w_count_d;
    logic         r_full, r_empty, r_rd_valid, r_ovf, r_unf;
    logic         w_in_flush, w_wr_acc, w_rd_acc;

    assign w_in_flush = (r_state == S_FLUSH);

    // Gated by reset so no strobe can fire while the FSM is held in reset.
    assign w_rd_acc = i_rst_n & i_rd_req & (r_state != S_EMPTY) & ~w_in_flush & ~i_flush;
    assign w_wr_acc = i_rst_n & i_wr_req & ((r_state != S_FULL) | w_rd_acc)
                    & ~w_in_flush & ~i_flush;

    always_comb begin
        w_state_d = r_state;
        w_wptr_d  = r_wptr;
        w_rptr_d  = r_rptr;
        w_count_d = r_count;
        if (i_flush) begin
            w_state_d = S_FLUSH;
            w_wptr_d  = '0;
            w_rptr_d  = '0;
            w_count_d = '0;
        end else if (w_in_flush) begin
            w_state_d = S_EMPTY;
            w_wptr_d  = '0;
            w_rptr_d  = '0;
            w_count_d = '0;
        end else begin
            if (w_wr_acc) w_wptr_d = r_wptr + PTR_1;
            if (w_rd_acc) w_rptr_d = r_rptr + PTR_1;
            if (w_wr_acc && !w_rd_acc) w_count_d = r_count + ONE;
            if (w_rd_acc && !w_wr_acc) w_count_d = r_count - ONE;
            case (r_state)
                S_EMPTY: if (w_wr_acc) w_state_d = S_MID;
                S_MID: begin
                    if (w_wr_acc && !w_rd_acc && r_count == LAST) begin
                        w_state_d = S_FULL;
                    end else if (w_rd_acc && !w_wr_acc && r_count == ONE) begin
                        w_state_d = S_EMPTY;
                    end
                end
                S_FULL:  if (w_rd_acc && !w_wr_acc) w_state_d = S_MID;
                default: w_state_d = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_EMPTY;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_rd_valid <= 1'b0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_wptr     <= w_wptr_d;
            r_rptr     <= w_rptr_d;
            r_count    <= w_count_d;
            r_full     <= (w_state_d == S_FULL);
            // The flush cycle holds no data, so it reads as empty.
            r_empty    <= (w_state_d == S_EMPTY) | (w_state_d == S_FLUSH);
            r_rd_valid <= w_rd_acc;
            r_ovf      <= i_wr_req & ~w_wr_acc & (r_state == S_FULL) & ~i_flush;
            r_unf      <= i_rd_req & (r_state == S_EMPTY) & ~i_flush;
        end
    end

`ifdef FIFO_ALMOST_FLAGS_EN
    localparam logic [K:0] AF_TH = DEPTH - (K+1)'(ALMOST_TH);
    localparam logic [K:0] AE_TH = (K+1)'(ALMOST_TH);

    logic r_almost_full, r_almost_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
        end else begin
            r_almost_full  <= (w_count_d >= AF_TH);
            r_almost_empty <= (w_count_d <= AE_TH);
        end
    end

    assign o_almost_full  = r_almost_full;
    assign o_almost_empty = r_almost_empty;
`endif

    assign o_ld_wr    = w_wr_acc;
    assign o_ld_rd    = w_rd_acc;
    assign o_wr_addr  = r_wptr;
    assign o_rd_addr  = r_rptr;
    assign o_rd_valid = r_rd_valid;
    assign o_full     = r_full;
    assign o_empty    = r_empty;
    assign o_count    = r_count;
    assign o_ovf      = r_ovf;
    assign o_unf      = r_unf;

endmodule
